// File: rtl/mano_io_ctrl.sv
// mano_io_ctrl: multi-channel character I/O controller. Each channel has one input
// FIFO (device -> CPU) and one output FIFO (CPU -> device), each with an FGI/FGO flag.
// It also has interrupt masks, a registered prioritised interrupt request and sticky error bits.
//
// Ports:
//   io_clock, io_reset_n              clock, async active-low reset
//   cpu_sel/cpu_inp/cpu_rdata         CPU pops one input character (registered result)
//   cpu_out/cpu_wdata                 CPU pushes one output character
//   cpu_mask_we/cpu_mask_i/cpu_mask_o interrupt mask load
//   cpu_err_clr                       clear sticky errors
//   io_fgi/io_fgo                     per-channel input-ready / output-space flags
//   io_irq/io_irq_chan                registered interrupt request, lowest pending channel
//   io_err                            [c] input underflow, [CHANNELS+c] output overflow
//   dev_in_*                          device -> input FIFO, valid/ready
//   dev_out_*                         output FIFO -> device, valid/ready
module mano_io_ctrl #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int CH_W     = 2
) (
  input  logic                         io_clock,
  input  logic                         io_reset_n,
  input  logic [CH_W-1:0]              cpu_sel,
  input  logic                         cpu_inp,
  output logic [DATA_W-1:0]            cpu_rdata,
  input  logic                         cpu_out,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_mask_we,
  input  logic [CHANNELS-1:0]          cpu_mask_i,
  input  logic [CHANNELS-1:0]          cpu_mask_o,
  input  logic                         cpu_err_clr,
  output logic [CHANNELS-1:0]          io_fgi,
  output logic [CHANNELS-1:0]          io_fgo,
  output logic                         io_irq,
  output logic [CH_W-1:0]              io_irq_chan,
  output logic [2*CHANNELS-1:0]        io_err,
  input  logic [CHANNELS*DATA_W-1:0]   dev_in_data,
  input  logic [CHANNELS-1:0]          dev_in_valid,
  output logic [CHANNELS-1:0]          dev_in_ready,
  output logic [CHANNELS*DATA_W-1:0]   dev_out_data,
  output logic [CHANNELS-1:0]          dev_out_valid,
  input  logic [CHANNELS-1:0]          dev_out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CHANNELS-1:0]   w_ifull, w_iempty, w_ipush, w_ipop, w_uflow;
  logic [CHANNELS-1:0]   w_ofull, w_oempty, w_opush, w_opop, w_oflow;
  logic [CHANNELS-1:0]   w_pend;
  logic [DATA_W-1:0]     w_ihead_dat [CHANNELS];
  logic [DATA_W-1:0]     w_rd_dat;
  logic [CH_W-1:0]       w_chan;

  logic [CHANNELS-1:0]   r_mask_i, r_mask_o;
  logic [2*CHANNELS-1:0] r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_irq;
  logic [CH_W-1:0]       r_irq_chan;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_W-1:0] r_imem [DEPTH];
      logic [PW-1:0]     r_ihead, r_itail;
      logic [CW-1:0]     r_icnt;
      logic [DATA_W-1:0] r_omem [DEPTH];
      logic [PW-1:0]     r_ohead, r_otail;
      logic [CW-1:0]     r_ocnt;
      logic              w_sel;

      // A cpu_sel beyond the last channel matches no channel, so strobes to it do nothing.
      assign w_sel = (cpu_sel == CH_W'(c));

      assign w_ifull[c]  = (r_icnt == FULL_CNT);
      assign w_iempty[c] = (r_icnt == '0);
      assign w_ofull[c]  = (r_ocnt == FULL_CNT);
      assign w_oempty[c] = (r_ocnt == '0);

      assign w_ipush[c] = dev_in_valid[c] & ~w_ifull[c];
      assign w_ipop[c]  = cpu_inp & w_sel & ~w_iempty[c];
      assign w_uflow[c] = cpu_inp & w_sel & w_iempty[c];
      // Full is taken from the registered count, so a device pop in the same cycle
      // does not make room for a CPU push.
      assign w_opush[c] = cpu_out & w_sel & ~w_ofull[c];
      assign w_oflow[c] = cpu_out & w_sel & w_ofull[c];
      assign w_opop[c]  = ~w_oempty[c] & dev_out_ready[c];

      assign w_ihead_dat[c] = r_imem[r_ihead];
      assign dev_out_data[c*DATA_W +: DATA_W] = r_omem[r_ohead];

      always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
          r_ihead <= '0;
          r_itail <= '0;
          r_icnt  <= '0;
          for (int i = 0; i < DEPTH; i++) r_imem[i] <= '0;
        end else begin
          if (w_ipush[c]) begin
            r_imem[r_itail] <= dev_in_data[c*DATA_W +: DATA_W];
            r_itail         <= r_itail + 1'b1;
          end
          if (w_ipop[c]) r_ihead <= r_ihead + 1'b1;
          case ({w_ipush[c], w_ipop[c]})
            2'b10:   r_icnt <= r_icnt + 1'b1;
            2'b01:   r_icnt <= r_icnt - 1'b1;
            default: r_icnt <= r_icnt;
          endcase
        end
      end

      always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
          r_ohead <= '0;
          r_otail <= '0;
          r_ocnt  <= '0;
          for (int i = 0; i < DEPTH; i++) r_omem[i] <= '0;
        end else begin
          if (w_opush[c]) begin
            r_omem[r_otail] <= cpu_wdata;
            r_otail         <= r_otail + 1'b1;
          end
          if (w_opop[c]) r_ohead <= r_ohead + 1'b1;
          case ({w_opush[c], w_opop[c]})
            2'b10:   r_ocnt <= r_ocnt + 1'b1;
            2'b01:   r_ocnt <= r_ocnt - 1'b1;
            default: r_ocnt <= r_ocnt;
          endcase
        end
      end
    end
  endgenerate

  assign io_fgi        = ~w_iempty;
  assign io_fgo        = ~w_ofull;
  assign dev_in_ready  = ~w_ifull;
  assign dev_out_valid = ~w_oempty;
  assign w_pend        = (r_mask_i & io_fgi) | (r_mask_o & io_fgo);

  // At most one channel matches cpu_sel, so at most one pop is active.
  always_comb begin
    w_rd_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ipop[k]) w_rd_dat = w_ihead_dat[k];
    end
  end

  // Scan from the top down so the lowest pending index is the one that remains.
  always_comb begin
    w_chan = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_pend[k]) w_chan = CH_W'(k);
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_rdata    <= '0;
      r_mask_i   <= '0;
      r_mask_o   <= '0;
      r_err      <= '0;
      r_irq      <= 1'b0;
      r_irq_chan <= '0;
    end else begin
      if (|w_ipop) r_rdata <= w_rd_dat;
      if (cpu_mask_we) begin
        r_mask_i <= cpu_mask_i;
        r_mask_o <= cpu_mask_o;
      end
      // A new error in the clearing cycle survives the clear.
      r_err <= (cpu_err_clr ? '0 : r_err) | {w_oflow, w_uflow};
      r_irq <= |w_pend;
      if (|w_pend) r_irq_chan <= w_chan;
    end
  end

  assign cpu_rdata   = r_rdata;
  assign io_err      = r_err;
  assign io_irq      = r_irq;
  assign io_irq_chan = r_irq_chan;

endmodule

// File: tb/tb_mano_io_ctrl.sv
// tb_mano_io_ctrl: directed bench for mano_io_ctrl (4 channels, 8-bit data, depth 4).
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_mano_io_ctrl;
  logic        io_clock = 1'b0;
  logic        io_reset_n;
  logic [1:0]  cpu_sel;
  logic        cpu_inp, cpu_out, cpu_mask_we, cpu_err_clr;
  logic [7:0]  cpu_rdata, cpu_wdata;
  logic [3:0]  cpu_mask_i, cpu_mask_o;
  logic [3:0]  io_fgi, io_fgo;
  logic        io_irq;
  logic [1:0]  io_irq_chan;
  logic [7:0]  io_err;
  logic [31:0] dev_in_data, dev_out_data;
  logic [3:0]  dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ready;

  int checks = 0;
  int failures = 0;

  always #5 io_clock = ~io_clock;

  mano_io_ctrl #(.CHANNELS(4), .DATA_W(8), .DEPTH(4), .CH_W(2)) dut (
    .io_clock(io_clock), .io_reset_n(io_reset_n),
    .cpu_sel(cpu_sel), .cpu_inp(cpu_inp), .cpu_rdata(cpu_rdata),
    .cpu_out(cpu_out), .cpu_wdata(cpu_wdata),
    .cpu_mask_we(cpu_mask_we), .cpu_mask_i(cpu_mask_i), .cpu_mask_o(cpu_mask_o),
    .cpu_err_clr(cpu_err_clr),
    .io_fgi(io_fgi), .io_fgo(io_fgo), .io_irq(io_irq), .io_irq_chan(io_irq_chan),
    .io_err(io_err),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready)
  );

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] base;
    io_reset_n = 1'b0;
    cpu_sel = '0; cpu_inp = 0; cpu_out = 0; cpu_wdata = '0;
    cpu_mask_we = 0; cpu_mask_i = '0; cpu_mask_o = '0; cpu_err_clr = 0;
    dev_in_data = '0; dev_in_valid = '0; dev_out_ready = '0;
    repeat (3) tick();
    io_reset_n = 1'b1;
    tick();

    // Idle state after reset
    chk("rst_fgi", 32'(io_fgi), 32'h0);
    chk("rst_fgo", 32'(io_fgo), 32'hF);
    chk("rst_in_rdy", 32'(dev_in_ready), 32'hF);
    chk("rst_out_vld", 32'(dev_out_valid), 32'h0);
    chk("rst_irq", 32'(io_irq), 32'h0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_err", 32'(io_err), 32'h0);

    // Input fill/drain on ch2, three rounds
    for (int r = 0; r < 3; r++) begin
      base = 8'h41 + 8'(r * 8);
      for (int i = 0; i < 4; i++) begin
        dev_in_valid = 4'b0100;
        dev_in_data[23:16] = base + 8'(i);
        tick();
      end
      dev_in_valid = '0;
      chk("in_full_rdy", 32'(dev_in_ready), 32'hB);
      chk("in_full_fgi", 32'(io_fgi), 32'h4);
      cpu_sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
        cpu_inp = 1; tick(); cpu_inp = 0;
        chk("pop_data", 32'(cpu_rdata), 32'(base + 8'(i)));
      end
      cpu_inp = 1; tick(); cpu_inp = 0;
      chk("uflow_rdata", 32'(cpu_rdata), 32'(base + 8'd3));
      chk("uflow_err", 32'(io_err), 32'h04);
      chk("empty_fgi", 32'(io_fgi), 32'h0);
      cpu_err_clr = 1; tick(); cpu_err_clr = 0;
      chk("err_clr", 32'(io_err), 32'h0);
    end

    // New error in the clearing cycle wins
    cpu_sel = 2'd2; cpu_inp = 1; cpu_err_clr = 1; tick();
    cpu_inp = 0; cpu_err_clr = 0;
    chk("clr_vs_new", 32'(io_err), 32'h04);
    cpu_err_clr = 1; tick(); cpu_err_clr = 0;

    // Output overflow on ch1
    dev_out_ready = '0; cpu_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("out_full_fgo", 32'(io_fgo), 32'hD);
      cpu_wdata = 8'h30 + 8'(i); cpu_out = 1; tick(); cpu_out = 0;
    end
    chk("oflow_err", 32'(io_err), 32'h20);
    chk("out_vld", 32'(dev_out_valid), 32'h2);
    dev_out_ready = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      chk("out_data", 32'(dev_out_data[15:8]), 32'(8'h30 + 8'(i)));
      tick();
    end
    dev_out_ready = '0;
    chk("out_drained", 32'(dev_out_valid), 32'h0);
    chk("out_fgo", 32'(io_fgo), 32'hF);
    cpu_err_clr = 1; tick(); cpu_err_clr = 0;

    // Full ch0 output: CPU push and device pop in the same cycle
    cpu_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cpu_wdata = 8'h50 + 8'(i); cpu_out = 1; tick(); cpu_out = 0;
    end
    cpu_wdata = 8'h54; cpu_out = 1; dev_out_ready = 4'b0001; tick();
    cpu_out = 0; dev_out_ready = '0;
    chk("simul_fgo", 32'(io_fgo), 32'hF);
    chk("simul_err", 32'(io_err), 32'h10);
    dev_out_ready = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      chk("simul_data", 32'(dev_out_data[7:0]), 32'(8'h51 + 8'(i)));
      tick();
    end
    dev_out_ready = '0;
    chk("simul_cnt3", 32'(dev_out_valid), 32'h0);
    cpu_err_clr = 1; tick(); cpu_err_clr = 0;

    // Interrupt priority with input masks 1010
    cpu_mask_i = 4'b1010; cpu_mask_o = '0; cpu_mask_we = 1; tick(); cpu_mask_we = 0;
    chk("irq_idle", 32'(io_irq), 32'h0);
    dev_in_valid = 4'b1000; dev_in_data[31:24] = 8'h61; tick(); dev_in_valid = '0;
    chk("irq_latency", 32'(io_irq), 32'h0);
    tick();
    chk("irq_ch3", 32'(io_irq), 32'h1);
    chk("irq_chan3", 32'(io_irq_chan), 32'h3);
    dev_in_valid = 4'b0010; dev_in_data[15:8] = 8'h62; tick(); dev_in_valid = '0;
    chk("irq_chan_lat", 32'(io_irq_chan), 32'h3);
    tick();
    chk("irq_chan1", 32'(io_irq_chan), 32'h1);
    cpu_sel = 2'd1; cpu_inp = 1; tick(); cpu_inp = 0;
    chk("irq_pop1", 32'(cpu_rdata), 32'h62);
    tick();
    chk("irq_back3", 32'(io_irq_chan), 32'h3);
    chk("irq_back3_irq", 32'(io_irq), 32'h1);
    // Pop and push on ch3 in the same cycle
    cpu_sel = 2'd3; cpu_inp = 1; cpu_out = 1; cpu_wdata = 8'h77; tick();
    cpu_inp = 0; cpu_out = 0;
    chk("both_rdata", 32'(cpu_rdata), 32'h61);
    chk("both_odata", 32'(dev_out_data[31:24]), 32'h77);
    chk("both_ovld", 32'(dev_out_valid), 32'h8);
    chk("irq_drain_lat", 32'(io_irq), 32'h1);
    tick();
    chk("irq_off", 32'(io_irq), 32'h0);
    chk("irq_chan_hold", 32'(io_irq_chan), 32'h3);
    // Output mask on ch2
    cpu_mask_i = '0; cpu_mask_o = 4'b0100; cpu_mask_we = 1; tick(); cpu_mask_we = 0;
    chk("mask_o_lat", 32'(io_irq), 32'h0);
    tick();
    chk("mask_o_irq", 32'(io_irq), 32'h1);
    chk("mask_o_chan", 32'(io_irq_chan), 32'h2);

    // Async reset with data buffered
    dev_in_valid = 4'b0001; dev_in_data[7:0] = 8'h88; tick(); tick(); dev_in_valid = '0;
    cpu_sel = 2'd1; cpu_inp = 1; tick(); cpu_inp = 0;
    chk("pre_rst_fgi", 32'(io_fgi), 32'h1);
    chk("pre_rst_err", 32'(io_err), 32'h02);
    #2 io_reset_n = 1'b0;
    #1;
    chk("arst_fgi", 32'(io_fgi), 32'h0);
    chk("arst_fgo", 32'(io_fgo), 32'hF);
    chk("arst_in_rdy", 32'(dev_in_ready), 32'hF);
    chk("arst_out_vld", 32'(dev_out_valid), 32'h0);
    chk("arst_irq", 32'(io_irq), 32'h0);
    chk("arst_rdata", 32'(cpu_rdata), 32'h0);
    chk("arst_err", 32'(io_err), 32'h0);
    tick();
    io_reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mano_io_ctrl.md
Name: mano_io_ctrl

Overview:
- Parametrised multi-channel character I/O controller; successor to the single INPR/OUTR/FGI/FGO pair in the Mano core.
- Provides CHANNELS independent input and output FIFOs, each with per-channel FGI/FGO flags.
- Adds per-channel interrupt masks, a prioritised interrupt request, and sticky error flags.
- Sits between the core's INP/OUT/SKI/SKO/interrupt logic and the external character devices.

Parameters:
CHANNELS, 4, number of I/O channels (1..16)
DATA_W, 8, character width
DEPTH, 4, entries per FIFO, power of two >= 2
CH_W, 2, channel-select width, = max(1, clog2(CHANNELS))

Ports:
io_clock  in  1  system clock; all state updates on rising edge
io_reset_n  in  1  asynchronous active-low reset
cpu_sel  in  CH_W  channel addressed by cpu_inp/cpu_out
cpu_inp  in  1  pop one input character from channel cpu_sel
cpu_rdata  out  DATA_W  registered popped character
cpu_out  in  1  push cpu_wdata to output FIFO of cpu_sel
cpu_wdata  in  DATA_W  character to output
cpu_mask_we  in  1  load interrupt masks
cpu_mask_i  in  CHANNELS  input-interrupt enables
cpu_mask_o  in  CHANNELS  output-interrupt enables
cpu_err_clr  in  1  clear all sticky error bits
io_fgi  out  CHANNELS  input flag per channel
io_fgo  out  CHANNELS  output flag per channel
io_irq  out  1  registered interrupt request
io_irq_chan  out  CH_W  lowest-numbered requesting channel
io_err  out  2*CHANNELS  sticky errors: [c] input underflow, [CHANNELS+c] output overflow
dev_in_data  in  CHANNELS*DATA_W  device characters; channel c at [c*DATA_W +: DATA_W]
dev_in_valid  in  CHANNELS  device offers a character
dev_in_ready  out  CHANNELS  input FIFO accepts
dev_out_data  out  CHANNELS*DATA_W  output FIFO heads
dev_out_valid  out  CHANNELS  output FIFO non-empty
dev_out_ready  in  CHANNELS  device consumes head

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; cpu_rdata=0; masks=0; io_irq=0; io_irq_chan=0; io_err=0.
  - Resulting outputs: io_fgi=0, io_fgo=all 1, dev_in_ready=all 1, dev_out_valid=0.
  - Mid-operation reset discards all buffered data.
- FIFO state per FIFO: head pointer, tail pointer, and count register of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Input path, channel c:
  - Push when dev_in_valid[c] & dev_in_ready[c].
  - dev_in_ready[c] = !full (registered count); no push at full, device holds data.
  - io_fgi[c] = !empty.
- CPU input read:
  - cpu_inp with FGI set pops the head of channel cpu_sel; cpu_rdata gets the head one cycle later and holds until the next successful pop.
  - cpu_inp on an empty channel: no pop, cpu_rdata unchanged, io_err[cpu_sel] set.
- Output path, channel c:
  - io_fgo[c] = !full.
  - cpu_out with FGO set pushes cpu_wdata.
  - cpu_out on a full channel: dropped, io_err[CHANNELS+cpu_sel] set. This holds even if the device pops the same cycle (full is judged from the registered count).
  - dev_out_valid[c] = !empty; dev_out_data = head; pop on valid & ready.
- Simultaneous push and pop on one FIFO: both take effect and count is unchanged, except a pop on empty (not possible, valid low) or a push on full (rejected as above).
- cpu_inp and cpu_out in the same cycle are independent and both execute.
- cpu_sel >= CHANNELS: strobe ignored, no error.
- Interrupts:
  - pend[c] = (mask_i[c] & io_fgi[c]) | (mask_o[c] & io_fgo[c]).
  - io_irq and io_irq_chan are registered from pend, one cycle latency.
  - io_irq_chan is the lowest-index pending channel; it holds its last value when io_irq=0.
- Masks load on cpu_mask_we; new masks affect io_irq on the following edge's evaluation.
- cpu_err_clr clears all error bits. A new error in the same cycle wins: the bit stays set.

Test Plan:
- Reset, then check idle outputs: io_fgi=0, io_fgo=4'hF, dev_in_ready=4'hF, io_irq=0, cpu_rdata=0.
- Input fill/drain and wrap: device pushes 0x41..0x44 on ch2 → dev_in_ready[2]=0 after the 4th push. Five cpu_inp (sel=2) → rdata 0x41,0x42,0x43,0x44 each one cycle after its strobe. 5th pop → io_err[2]=1, rdata stays 0x44. Repeat twice to exercise pointer wrap.
- Output overflow: dev_out_ready=0; cpu_out 0x30..0x34 on ch1 → io_fgo[1]=0 after 4 pushes, io_err[5]=1, 0x34 lost. Then ready=1 → device sees 0x30..0x33 in order.
- Full simultaneous: ch0 output full, cpu_out and dev pop in the same cycle → push rejected, count=3, overflow flagged.
- Interrupt priority: mask_i=4'b1010; chars on ch3 then ch1 → io_irq=1, io_irq_chan=3, then 1 once ch1 fills. Drain ch1 → io_irq_chan=3. Drain all → io_irq=0 one cycle later.
- Async reset asserted mid-transfer with FIFOs half full → outputs reach reset values without a clock edge.
